// File: rtl/float_mul_pipe.sv
// Three-stage float32 multiplier (unpack, multiply, normalize/pack) with a
// valid/ready handshake and a single global stall shared by every stage.
module float_mul_pipe #(
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      floatA,
  input  logic [31:0]      floatB,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      ans,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic adv;

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_sign_q,  s1_sign_d;
  logic                    s1_zero_q,  s1_zero_d;
  logic signed [9:0]       s1_e_q,     s1_e_d;
  logic [23:0]             s1_ma_q,    s1_ma_d;
  logic [23:0]             s1_mb_q,    s1_mb_d;
  logic [TAG_W-1:0]        s1_tag_q,   s1_tag_d;

  logic                    s2_valid_q, s2_valid_d;
  logic                    s2_sign_q,  s2_sign_d;
  logic                    s2_zero_q,  s2_zero_d;
  logic signed [9:0]       s2_e_q,     s2_e_d;
  logic [24:0]             s2_prod_q,  s2_prod_d;
  logic [TAG_W-1:0]        s2_tag_q,   s2_tag_d;

  logic                    s3_valid_q, s3_valid_d;
  logic [31:0]             s3_ans_q,   s3_ans_d;
  logic [TAG_W-1:0]        s3_tag_q,   s3_tag_d;

  logic signed [9:0]       norm_e;
  logic [22:0]             norm_frac;
  logic [31:0]             packed_ans;

  assign adv       = !s3_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = s3_valid_q;
  assign ans       = s3_ans_q;
  assign out_tag   = s3_tag_q;
  assign busy      = s1_valid_q || s2_valid_q || s3_valid_q;

  // s2_prod holds product bits [47:23]; bit 24 is the carry-out of 1.x * 1.x.
  always_comb begin
    if (s2_prod_q[24]) begin
      norm_e    = s2_e_q + 10'sd1;
      norm_frac = s2_prod_q[23:1];
    end else begin
      norm_e    = s2_e_q;
      norm_frac = s2_prod_q[22:0];
    end

    if (s2_zero_q) begin
      packed_ans = '0;
    end else if (norm_e <= 10'sd0) begin
      packed_ans = '0;
    end else if (norm_e >= 10'sd255) begin
      packed_ans = {s2_sign_q, 8'hFE, 23'h7FFFFF};
    end else begin
      packed_ans = {s2_sign_q, norm_e[7:0], norm_frac};
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_e_d     = s1_e_q;
    s1_ma_d    = s1_ma_q;
    s1_mb_d    = s1_mb_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_e_d     = s2_e_q;
    s2_prod_d  = s2_prod_q;
    s2_tag_d   = s2_tag_q;
    s3_valid_d = s3_valid_q;
    s3_ans_d   = s3_ans_q;
    s3_tag_d   = s3_tag_q;

    if (adv) begin
      s1_valid_d = in_valid;
      s1_sign_d  = floatA[31] ^ floatB[31];
      s1_zero_d  = (floatA[30:23] == 8'd0) || (floatB[30:23] == 8'd0);
      s1_e_d     = $signed({2'b00, floatA[30:23]}) + $signed({2'b00, floatB[30:23]}) - 10'sd127;
      s1_ma_d    = {1'b1, floatA[22:0]};
      s1_mb_d    = {1'b1, floatB[22:0]};
      s1_tag_d   = in_tag;

      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_zero_d  = s1_zero_q;
      s2_e_d     = s1_e_q;
      s2_prod_d  = 25'((48'(s1_ma_q) * 48'(s1_mb_q)) >> 23);
      s2_tag_d   = s1_tag_q;

      // Result registers only load on real data so ans/out_tag keep the last product through bubbles.
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_ans_d = packed_ans;
        s3_tag_d = s2_tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_e_q     <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_e_q     <= '0;
      s2_prod_q  <= '0;
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_ans_q   <= '0;
      s3_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_e_q     <= s1_e_d;
      s1_ma_q    <= s1_ma_d;
      s1_mb_q    <= s1_mb_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_e_q     <= s2_e_d;
      s2_prod_q  <= s2_prod_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      s3_ans_q   <= s3_ans_d;
      s3_tag_q   <= s3_tag_d;
    end
  end

endmodule

// File: tb/tb_float_mul_pipe.sv
// Directed-vector bench for float_mul_pipe: latency, arithmetic corner cases,
// backpressure ordering and mid-flight reset.
module tb_float_mul_pipe;

  localparam int unsigned TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      floatA;
  logic [31:0]      floatB;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      ans;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  always #5 clk = ~clk;

  float_mul_pipe #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .floatA    (floatA),
    .floatB    (floatB),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ans       (ans),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] tv_a [32];
  logic [31:0] tv_b [32];
  logic [31:0] tv_p [32];
  logic [31:0] bp_b [5];
  logic [31:0] bp_p [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_busy"},      32'(busy),      32'd0);
    check({name, "_ans"},       ans,            32'h0);
    check({name, "_out_tag"},   32'(out_tag),   32'd0);
    check({name, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // Single 2.0 x 3.0 transaction, checking exact two-edge latency.
  task automatic single_op(input string name, input logic [7:0] tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    floatA    = 32'h40000000;
    floatB    = 32'h40400000;
    in_tag    = tag;
    step();
    in_valid = 1'b0;
    check({name, "_n0_valid"}, 32'(out_valid), 32'd0);
    check({name, "_n0_busy"},  32'(busy),      32'd1);
    step();
    check({name, "_n1_valid"}, 32'(out_valid), 32'd0);
    step();
    check({name, "_n2_valid"}, 32'(out_valid), 32'd1);
    check({name, "_n2_ans"},   ans,            32'h40C00000);
    check({name, "_n2_tag"},   32'(out_tag),   32'(tag));
    step();
    check({name, "_n3_valid"}, 32'(out_valid), 32'd0);
    check({name, "_n3_busy"},  32'(busy),      32'd0);
  endtask

  // Back-to-back vectors tv_*[first .. first+n-1]; result j must appear k = j+2 steps after the first accept.
  task automatic run_stream(input int first, input int n, input string name);
    int rcv;
    rcv = 0;
    out_ready = 1'b1;
    for (int k = 0; k < n + 4; k++) begin
      if (k < n) begin
        in_valid = 1'b1;
        floatA   = tv_a[first + k];
        floatB   = tv_b[first + k];
        in_tag   = 8'(first + k + 32);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid) begin
        if (rcv < n) begin
          check($sformatf("%s_%0d_ans", name, rcv), ans, tv_p[first + rcv]);
          check($sformatf("%s_%0d_tag", name, rcv), 32'(out_tag), 32'(first + rcv + 32));
          check($sformatf("%s_%0d_cycle", name, rcv), 32'(k), 32'(rcv + 2));
        end else begin
          check($sformatf("%s_extra", name), 32'(rcv), 32'(n));
        end
        rcv++;
      end
    end
    check({name, "_count"}, 32'(rcv), 32'(n));
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    tv_a[i] = a;
    tv_b[i] = b;
    tv_p[i] = p;
  endtask

  initial begin
    int acc;
    int rcv;
    logic fire;

    // Normalization carry and sign
    load(0,  32'h3FC00000, 32'h3FC00000, 32'h40100000);
    load(1,  32'hBF800000, 32'h3F000000, 32'hBF000000);
    // Zero and underflow
    load(2,  32'h00000000, 32'hC2000000, 32'h00000000);
    load(3,  32'h80000000, 32'h3F800000, 32'h00000000);
    load(4,  32'h00800000, 32'h00800000, 32'h00000000);
    load(5,  32'h00800000, 32'h3F800000, 32'h00800000);
    load(6,  32'h00800000, 32'h3F000000, 32'h00000000);
    load(7,  32'h00C00000, 32'h3F400000, 32'h00900000);
    load(8,  32'h00400000, 32'h3F800000, 32'h00000000);
    load(9,  32'h00000000, 32'h7F800000, 32'h00000000);
    // Overflow, saturation boundary and truncation
    load(10, 32'h7F000000, 32'h7F000000, 32'h7F7FFFFF);
    load(11, 32'hFF000000, 32'h7F000000, 32'hFF7FFFFF);
    load(12, 32'h7F800000, 32'h3F800000, 32'h7F7FFFFF);
    load(13, 32'h7F000000, 32'h40000000, 32'h7F7FFFFF);
    load(14, 32'h7F000000, 32'h3F800000, 32'h7F000000);
    load(15, 32'h3F800001, 32'h3F800001, 32'h3F800002);
    load(16, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);

    bp_b[0] = 32'h3F800000; bp_p[0] = 32'h40000000;
    bp_b[1] = 32'h40000000; bp_p[1] = 32'h40800000;
    bp_b[2] = 32'h40400000; bp_p[2] = 32'h40C00000;
    bp_b[3] = 32'h40800000; bp_p[3] = 32'h41000000;
    bp_b[4] = 32'h40A00000; bp_p[4] = 32'h41200000;

    rst       = 1'b1;
    in_valid  = 1'b0;
    floatA    = '0;
    floatB    = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_idle("reset");

    single_op("basic", 8'h11);
    run_stream(0,  2, "norm");
    run_stream(2,  8, "zero");
    run_stream(10, 7, "ovf");

    // Backpressure: with out_ready low only three pairs fit before the stall.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (acc < 5);
      if (acc < 5) begin
        floatA = 32'h40000000;
        floatB = bp_b[acc];
        in_tag = 8'(acc + 1);
      end
      #1;
      fire = in_valid && in_ready;
      step();
      if (fire) acc++;
    end
    check("bp_accepted",  32'(acc),       32'd3);
    check("bp_in_ready",  32'(in_ready),  32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_ans_hold",  ans,            bp_p[0]);
    check("bp_tag_hold",  32'(out_tag),   32'd1);
    step();
    check("bp_ans_hold2", ans,            bp_p[0]);
    check("bp_tag_hold2", 32'(out_tag),   32'd1);

    out_ready = 1'b1;
    rcv = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (acc < 5);
      if (acc < 5) begin
        floatA = 32'h40000000;
        floatB = bp_b[acc];
        in_tag = 8'(acc + 1);
      end
      #1;
      fire = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (rcv < 5) begin
          check($sformatf("bp_%0d_ans", rcv), ans, bp_p[rcv]);
          check($sformatf("bp_%0d_tag", rcv), 32'(out_tag), 32'(rcv + 1));
          check($sformatf("bp_%0d_cycle", rcv), 32'(c), 32'(rcv));
        end else begin
          check("bp_extra", 32'(rcv), 32'd5);
        end
        rcv++;
      end
      step();
      if (fire) acc++;
    end
    check("bp_released", 32'(rcv),       32'd5);
    check("bp_drained",  32'(out_valid), 32'd0);
    check("bp_idle",     32'(busy),      32'd0);

    // Reset with three pairs in flight.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      floatA   = tv_a[k];
      floatB   = tv_b[k];
      in_tag   = 8'(k + 64);
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_idle("midrst");
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("midrst_quiet_%0d", k), 32'(out_valid), 32'd0);
    end

    single_op("post_rst", 8'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
